mul_flag_unit: RTL and testbench

//  Multi-cycle MUL/MLA execution unit for the ARM datapath; the producer side of the ALUFlags/FlagW interface.

---
 rtl/mul_flag_unit_if.sv | 28 ++
 rtl/mul_flag_unit.sv | 141 ++++++++++++++
 tb/tb_mul_flag_unit.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mul_flag_unit_if.sv
// rtl/mul_flag_unit_if.sv - launch/operand and result/flag bundle for the multi-cycle MUL/MLA unit
interface mul_flag_unit_if #(
  parameter int WIDTH = 32
);
  logic             Start;
  logic             Acc;
  logic             SetFlags;
  logic [WIDTH-1:0] SrcA;
  logic [WIDTH-1:0] SrcB;
  logic [WIDTH-1:0] SrcAcc;
  logic             OldC;
  logic             OldV;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Result;
  logic [3:0]       ALUFlags;
  logic [1:0]       FlagWOut;

  modport master (
    output Start, Acc, SetFlags, SrcA, SrcB, SrcAcc, OldC, OldV,
    input  Busy, Done, Result, ALUFlags, FlagWOut
  );

  modport slave (
    input  Start, Acc, SetFlags, SrcA, SrcB, SrcAcc, OldC, OldV,
    output Busy, Done, Result, ALUFlags, FlagWOut
  );
endinterface

// File: rtl/mul_flag_unit.sv
// rtl/mul_flag_unit.sv - shift-add MUL/MLA unit producing Result, {N,Z,C,V} and flag-write enables
module mul_flag_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  mul_flag_unit_if.slave bus
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] partial;
  logic [CW-1:0]    cnt;
  logic             setflags_q;
  logic             oldc_q;
  logic             oldv_q;
  logic [WIDTH-1:0] result_q;
  logic [3:0]       flags_q;
  logic [WIDTH-1:0] acc_sum;

  logic             busy;
  logic             done;
  logic [1:0]       flagw;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a fixed WIDTH-step RUN phase, no early exit on a zero multiplier
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (bus.Start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = ACC;
      ACC:     state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; flag writes are confined to the single DONE cycle
  always_comb begin
    busy  = 1'b0;
    done  = 1'b0;
    flagw = 2'b00;
    case (state)
      IDLE: begin
        busy = 1'b0;
      end
      RUN, ACC: begin
        busy = 1'b1;
      end
      DONE: begin
        busy  = 1'b1;
        done  = 1'b1;
        flagw = {setflags_q, 1'b0};
      end
      default: begin
        busy = 1'b0;
      end
    endcase
  end

  assign acc_sum = partial + acc_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand      <= '0;
      mplier     <= '0;
      acc_q      <= '0;
      partial    <= '0;
      cnt        <= '0;
      setflags_q <= 1'b0;
      oldc_q     <= 1'b0;
      oldv_q     <= 1'b0;
      result_q   <= '0;
      flags_q    <= 4'b0000;
    end else begin
      case (state)
        IDLE: begin
          if (bus.Start) begin
            mcand      <= bus.SrcA;
            mplier     <= bus.SrcB;
            acc_q      <= bus.Acc ? bus.SrcAcc : '0;
            setflags_q <= bus.SetFlags;
            oldc_q     <= bus.OldC;
            oldv_q     <= bus.OldV;
            partial    <= '0;
            cnt        <= '0;
          end
        end
        RUN: begin
          if (mplier[0]) begin
            partial <= partial + mcand;
          end
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
        end
        ACC: begin
          // Result and flags are captured on the edge entering DONE so they are valid with Done
          partial  <= acc_sum;
          result_q <= acc_sum;
          flags_q  <= {acc_sum[WIDTH-1], (acc_sum == '0), oldc_q, oldv_q};
        end
        DONE: begin
          cnt <= '0;
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  assign bus.Busy     = busy;
  assign bus.Done     = done;
  assign bus.FlagWOut = flagw;
  assign bus.Result   = result_q;
  assign bus.ALUFlags = flags_q;

endmodule

// File: tb/tb_mul_flag_unit.sv
// tb/tb_mul_flag_unit.sv - randomized self-checking bench for mul_flag_unit against an arithmetic model
module tb_mul_flag_unit;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic clk;
  logic reset;
  int   n_vec;
  int   n_err;

  mul_flag_unit_if #(.WIDTH(W)) bus ();

  mul_flag_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_res(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic [W-1:0] c, input logic accen);
    logic [2*W-1:0] p;
    p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    return p[W-1:0] + (accen ? c : {W{1'b0}});
  endfunction

  function automatic logic [3:0] model_flags(input logic [W-1:0] r, input logic oc, input logic ov);
    return {r[W-1], (r == {W{1'b0}}), oc, ov};
  endfunction

  task automatic drive_idle();
    bus.Start    = 1'b0;
    bus.Acc      = 1'($urandom);
    bus.SetFlags = 1'($urandom);
    bus.SrcA     = $urandom;
    bus.SrcB     = $urandom;
    bus.SrcAcc   = $urandom;
    bus.OldC     = 1'($urandom);
    bus.OldV     = 1'($urandom);
  endtask

  // Launch one op and watch it; lat=0 means no Done within the cycle budget
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] c,
                        input logic accen, input logic s, input logic oc, input logic ov,
                        output int lat, output logic [W-1:0] res, output logic [3:0] fl,
                        output logic [1:0] fw, output int busy_cnt, output int fw_bad);
    @(negedge clk);
    bus.Start = 1'b1; bus.SrcA = a; bus.SrcB = b; bus.SrcAcc = c;
    bus.Acc = accen; bus.SetFlags = s; bus.OldC = oc; bus.OldV = ov;
    lat = 0; busy_cnt = 0; fw_bad = 0; res = '0; fl = '0; fw = '0;
    for (int k = 1; k <= 3 * LAT; k++) begin
      @(negedge clk);
      if (k == 1) drive_idle();
      if (bus.Busy) busy_cnt++;
      if (!bus.Done && bus.FlagWOut !== 2'b00) fw_bad++;
      if (bus.Done) begin
        lat = k; res = bus.Result; fl = bus.ALUFlags; fw = bus.FlagWOut;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive_idle();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({bus.Busy, bus.Done, bus.FlagWOut} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctrl busy/done/fw got %b want 0000", {bus.Busy, bus.Done, bus.FlagWOut});
    end
    n_vec++;
    if ({bus.Result, bus.ALUFlags} !== {(W+4){1'b0}}) begin
      n_err++; $display("FAIL reset_data result=%h flags=%b want 0", bus.Result, bus.ALUFlags);
    end
    // Start and reset together: reset wins
    bus.Start = 1'b1; reset = 1'b1;
    @(negedge clk);
    bus.Start = 1'b0; reset = 1'b0;
    @(negedge clk);
    n_vec++;
    if (bus.Busy !== 1'b0) begin
      n_err++; $display("FAIL start_with_reset busy got %b want 0", bus.Busy);
    end
  endtask

  task automatic test_directed();
    int lat, bc, fb;
    logic [W-1:0] r;
    logic [3:0] f;
    logic [1:0] fw;
    run_op(32'd3, 32'd5, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b1, 1'b0, lat, r, f, fw, bc, fb);
    n_vec++;
    if (lat !== LAT || r !== 32'd15 || f !== 4'b0010 || fw !== 2'b10) begin
      n_err++; $display("FAIL mul_3x5 lat=%0d res=%0d flags=%b fw=%b want %0d 15 0010 10", lat, r, f, fw, LAT);
    end
    run_op(32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, lat, r, f, fw, bc, fb);
    n_vec++;
    if (r !== 32'hFFFF_FFFF || f[3:2] !== 2'b10) begin
      n_err++; $display("FAIL mla_neg res=%h nz=%b want ffffffff 10", r, f[3:2]);
    end
    run_op(32'h1_0000, 32'h1_0000, 32'd0, 1'b0, 1'b1, 1'b0, 1'b1, lat, r, f, fw, bc, fb);
    n_vec++;
    if (r !== 32'd0 || f !== 4'b0101) begin
      n_err++; $display("FAIL mul_wrap res=%h flags=%b want 0 0101", r, f);
    end
    run_op(32'd7, 32'd6, 32'hFFFF_FFD6, 1'b1, 1'b1, 1'b1, 1'b1, lat, r, f, fw, bc, fb);
    n_vec++;
    if (r !== 32'd0 || f !== 4'b0111) begin
      n_err++; $display("FAIL mla_wrap res=%h flags=%b want 0 0111", r, f);
    end
    run_op(32'd9, 32'd9, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, lat, r, f, fw, bc, fb);
    n_vec++;
    if (r !== 32'd81 || fw !== 2'b00 || fb !== 0) begin
      n_err++; $display("FAIL mul_nos res=%0d fw=%b fw_bad=%0d want 81 00 0", r, fw, fb);
    end
    n_vec++;
    if (bc !== LAT) begin
      n_err++; $display("FAIL busy_len got %0d want %0d", bc, LAT);
    end
    @(negedge clk);
    n_vec++;
    if (bus.Busy !== 1'b0 || bus.Result !== 32'd81 || bus.FlagWOut !== 2'b00) begin
      n_err++; $display("FAIL post_done busy=%b res=%0d fw=%b want 0 81 00", bus.Busy, bus.Result, bus.FlagWOut);
    end
  endtask

  task automatic test_random();
    int lat, bc, fb;
    logic [W-1:0] r, a, b, c;
    logic [3:0] f;
    logic [1:0] fw;
    logic accen, s, oc, ov;
    for (int i = 0; i < 24; i++) begin
      a = $urandom; b = $urandom; c = $urandom;
      case ($urandom_range(0, 3))
        0: begin a = W'($urandom_range(0, 255)); b = W'($urandom_range(0, 255)); end
        1: begin a = {W{1'b1}}; end
        2: begin b = '0; end
        default: ;
      endcase
      accen = 1'($urandom); s = 1'($urandom); oc = 1'($urandom); ov = 1'($urandom);
      run_op(a, b, c, accen, s, oc, ov, lat, r, f, fw, bc, fb);
      n_vec++;
      if (lat !== LAT || r !== model_res(a, b, c, accen)) begin
        n_err++; $display("FAIL rand_res[%0d] lat=%0d res=%h want %0d %h", i, lat, r, LAT, model_res(a, b, c, accen));
      end
      n_vec++;
      if (f !== model_flags(model_res(a, b, c, accen), oc, ov) || fw !== {s, 1'b0} || fb !== 0) begin
        n_err++; $display("FAIL rand_flags[%0d] flags=%b fw=%b fw_bad=%0d want %b %b 0", i, f, fw, fb,
                          model_flags(model_res(a, b, c, accen), oc, ov), {s, 1'b0});
      end
    end
  endtask

  task automatic test_restart_ignored();
    int done_at, busy_after;
    logic [W-1:0] r;
    @(negedge clk);
    bus.Start = 1'b1; bus.SrcA = 32'd1234; bus.SrcB = 32'd4321; bus.Acc = 1'b0;
    bus.SetFlags = 1'b1; bus.OldC = 1'b0; bus.OldV = 1'b0;
    done_at = 0; r = '0;
    for (int k = 1; k <= 3 * LAT; k++) begin
      @(negedge clk);
      drive_idle();
      if (k == 5 || k == 20) begin
        bus.Start = 1'b1; bus.SrcA = 32'd77; bus.SrcB = 32'd88; bus.Acc = 1'b1; bus.SrcAcc = 32'd5;
      end
      if (bus.Done) begin done_at = k; r = bus.Result; break; end
    end
    n_vec++;
    if (done_at !== LAT || r !== 32'd5332114) begin
      n_err++; $display("FAIL restart_first done_at=%0d res=%0d want %0d 5332114", done_at, r, LAT);
    end
    busy_after = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.Busy) busy_after++;
    end
    n_vec++;
    if (busy_after !== 0 || bus.Result !== 32'd5332114) begin
      n_err++; $display("FAIL restart_queued busy_cycles=%0d res=%0d want 0 5332114", busy_after, bus.Result);
    end
  endtask

  task automatic test_midop_reset();
    int lat, bc, fb, stray;
    logic [W-1:0] r;
    logic [3:0] f;
    logic [1:0] fw;
    @(negedge clk);
    bus.Start = 1'b1; bus.SrcA = 32'd11; bus.SrcB = 32'd13; bus.Acc = 1'b0;
    bus.SetFlags = 1'b1; bus.OldC = 1'b1; bus.OldV = 1'b1;
    repeat (10) begin
      @(negedge clk);
      drive_idle();
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_vec++;
    if (bus.Busy !== 1'b0 || bus.Result !== '0 || bus.ALUFlags !== 4'b0000) begin
      n_err++; $display("FAIL midop_reset busy=%b res=%h flags=%b want 0 0 0", bus.Busy, bus.Result, bus.ALUFlags);
    end
    stray = 0;
    repeat (LAT + 4) begin
      @(negedge clk);
      if (bus.Done || bus.Busy) stray++;
    end
    n_vec++;
    if (stray !== 0) begin
      n_err++; $display("FAIL midop_stray active_cycles=%0d want 0", stray);
    end
    run_op(32'd11, 32'd13, 32'd100, 1'b1, 1'b1, 1'b0, 1'b1, lat, r, f, fw, bc, fb);
    n_vec++;
    if (lat !== LAT || r !== 32'd243 || f !== 4'b0001 || fw !== 2'b10) begin
      n_err++; $display("FAIL after_reset lat=%0d res=%0d flags=%b fw=%b want %0d 243 0001 10", lat, r, f, fw, LAT);
    end
  endtask

  task automatic test_back_to_back();
    int lat, bc, fb;
    logic [W-1:0] r, a, b;
    logic [3:0] f;
    logic [1:0] fw;
    for (int i = 0; i < 4; i++) begin
      a = $urandom; b = $urandom;
      run_op(a, b, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, lat, r, f, fw, bc, fb);
      n_vec++;
      if (lat !== LAT || bc !== LAT || r !== model_res(a, b, 32'd0, 1'b0)) begin
        n_err++; $display("FAIL b2b[%0d] lat=%0d busy=%0d res=%h want %0d %0d %h", i, lat, bc, r, LAT, LAT,
                          model_res(a, b, 32'd0, 1'b0));
      end
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    drive_idle();
    test_reset();
    test_directed();
    test_random();
    test_restart_ignored();
    test_midop_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
